// File: rtl/ldtu_stream_decoder_if.sv
// Word-in / sample-out bundle between the DATA32 deserializer, the stream decoder and its consumer.
interface ldtu_stream_decoder_if #(
    parameter int Nbits_12   = 12,
    parameter int Nbits_32   = 32,
    parameter int ErrCntBits = 8
);
    logic [Nbits_32-1:0]   word_in;
    logic                  word_valid;
    logic                  word_ready;
    logic                  sample_valid;
    logic [Nbits_12:0]     sample_data;
    logic                  sample_is_bsl;
    logic                  frame_end;
    logic                  frame_err;
    logic                  hdr_err;
    logic [ErrCntBits-1:0] err_count;

    modport slave (
        input  word_in, word_valid,
        output word_ready, sample_valid, sample_data, sample_is_bsl,
               frame_end, frame_err, hdr_err, err_count
    );

    modport master (
        output word_in, word_valid,
        input  word_ready, sample_valid, sample_data, sample_is_bsl,
               frame_end, frame_err, hdr_err, err_count
    );
endinterface

// File: rtl/ldtu_stream_decoder.sv
// LiTE-DTU DATA32 stream decoder: unpacks baseline/signal words into one 13-bit sample
// per clock and checks each frame trailer against the running data-word count.
module ldtu_stream_decoder #(
    parameter int                  Nbits_12   = 12,
    parameter int                  Nbits_32   = 32,
    parameter int                  ErrCntBits = 8,
    parameter logic [Nbits_32-1:0] IDLE_WORD  = 32'hEAAAAAAA
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    ldtu_stream_decoder_if.slave bus
);
    localparam int SW = Nbits_12 + 1;

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_UNPACK = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [4*SW-1:0]       buf_q, buf_d;
    logic [2:0]            left_q, left_d;
    logic                  bsl_q, bsl_d;
    logic                  ready_q, ready_d;
    logic                  sample_valid_q, sample_valid_d;
    logic [SW-1:0]         sample_data_q, sample_data_d;
    logic                  sample_is_bsl_q, sample_is_bsl_d;
    logic                  frame_end_q, frame_end_d;
    logic                  frame_err_q, frame_err_d;
    logic                  hdr_err_q, hdr_err_d;
    logic [ErrCntBits-1:0] err_count_q, err_count_d;
    logic [7:0]            word_cnt_q, word_cnt_d;
    logic [7:0]            prev_fn_q, prev_fn_d;
    logic                  have_prev_q, have_prev_d;

    logic [Nbits_32-1:0]   w_s;
    logic                  accept_s;
    logic                  is_idle_s, is_bsl_s, is_sx2_s, is_sx1_s, is_trl_s;
    logic [7:0]            trl_fn_s, trl_cnt_s;

    assign w_s       = bus.word_in;
    assign accept_s  = bus.word_valid & ready_q;
    assign is_idle_s = (w_s == IDLE_WORD);
    assign is_bsl_s  = (w_s[31:30] == 2'b01);
    assign is_sx2_s  = (w_s[31:26] == 6'b001010);
    assign is_sx1_s  = (w_s[31:26] == 6'b001011);
    assign is_trl_s  = (w_s[31:28] == 4'b1101);
    assign trl_fn_s  = w_s[27:20];
    assign trl_cnt_s = w_s[19:12];

    // Next-state: emit buffered samples, decode accepted words, run the frame check.
    always_comb begin
        state_d         = state_q;
        buf_d           = buf_q;
        left_d          = left_q;
        bsl_d           = bsl_q;
        sample_valid_d  = 1'b0;
        sample_data_d   = sample_data_q;
        sample_is_bsl_d = sample_is_bsl_q;
        frame_end_d     = 1'b0;
        frame_err_d     = 1'b0;
        hdr_err_d       = 1'b0;
        word_cnt_d      = word_cnt_q;
        prev_fn_d       = prev_fn_q;
        have_prev_d     = have_prev_q;
        err_count_d     = err_count_q;

        case (state_q)
            ST_UNPACK: begin
                sample_valid_d  = 1'b1;
                sample_data_d   = buf_q[4*SW-1 -: SW];
                sample_is_bsl_d = bsl_q;
                buf_d           = {buf_q[3*SW-1:0], {SW{1'b0}}};
                left_d          = left_q - 3'd1;
                if (left_q == 3'd1) begin
                    state_d = ST_ACCEPT;
                end else begin
                    state_d = ST_UNPACK;
                end
            end
            ST_ACCEPT: begin
                // The first sample of a data word goes straight out; the rest wait in buf.
                if (!accept_s) begin
                    state_d = ST_ACCEPT;
                end else if (is_idle_s) begin
                    state_d = ST_ACCEPT;
                end else if (is_bsl_s) begin
                    sample_valid_d  = 1'b1;
                    sample_data_d   = {{(SW-6){1'b0}}, w_s[29:24]};
                    sample_is_bsl_d = 1'b1;
                    bsl_d           = 1'b1;
                    buf_d           = {{(SW-6){1'b0}}, w_s[23:18], {(SW-6){1'b0}}, w_s[17:12],
                                       {(SW-6){1'b0}}, w_s[11:6],  {(SW-6){1'b0}}, w_s[5:0]};
                    left_d          = 3'd4;
                    state_d         = ST_UNPACK;
                    word_cnt_d      = word_cnt_q + 8'd1;
                end else if (is_sx2_s) begin
                    sample_valid_d  = 1'b1;
                    sample_data_d   = w_s[25:13];
                    sample_is_bsl_d = 1'b0;
                    bsl_d           = 1'b0;
                    buf_d           = {w_s[12:0], {(3*SW){1'b0}}};
                    left_d          = 3'd1;
                    state_d         = ST_UNPACK;
                    word_cnt_d      = word_cnt_q + 8'd1;
                end else if (is_sx1_s) begin
                    sample_valid_d  = 1'b1;
                    sample_data_d   = w_s[12:0];
                    sample_is_bsl_d = 1'b0;
                    bsl_d           = 1'b0;
                    left_d          = 3'd0;
                    state_d         = ST_ACCEPT;
                    word_cnt_d      = word_cnt_q + 8'd1;
                end else if (is_trl_s) begin
                    frame_end_d = 1'b1;
                    frame_err_d = (trl_cnt_s != word_cnt_q) ||
                                  (have_prev_q && (trl_fn_s != (prev_fn_q + 8'd1)));
                    prev_fn_d   = trl_fn_s;
                    have_prev_d = 1'b1;
                    word_cnt_d  = 8'd0;
                end else begin
                    hdr_err_d  = 1'b1;
                    word_cnt_d = word_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase

        if ((frame_err_d || hdr_err_d) && (err_count_q != {ErrCntBits{1'b1}})) begin
            err_count_d = err_count_q + {{(ErrCntBits-1){1'b0}}, 1'b1};
        end else begin
            err_count_d = err_count_q;
        end

        ready_d = (state_d == ST_ACCEPT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q         <= ST_ACCEPT;
            buf_q           <= {(4*SW){1'b0}};
            left_q          <= 3'd0;
            bsl_q           <= 1'b0;
            ready_q         <= 1'b0;
            sample_valid_q  <= 1'b0;
            sample_data_q   <= {SW{1'b0}};
            sample_is_bsl_q <= 1'b0;
            frame_end_q     <= 1'b0;
            frame_err_q     <= 1'b0;
            hdr_err_q       <= 1'b0;
            err_count_q     <= {ErrCntBits{1'b0}};
            word_cnt_q      <= 8'd0;
            prev_fn_q       <= 8'd0;
            have_prev_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            buf_q           <= buf_d;
            left_q          <= left_d;
            bsl_q           <= bsl_d;
            ready_q         <= ready_d;
            sample_valid_q  <= sample_valid_d;
            sample_data_q   <= sample_data_d;
            sample_is_bsl_q <= sample_is_bsl_d;
            frame_end_q     <= frame_end_d;
            frame_err_q     <= frame_err_d;
            hdr_err_q       <= hdr_err_d;
            err_count_q     <= err_count_d;
            word_cnt_q      <= word_cnt_d;
            prev_fn_q       <= prev_fn_d;
            have_prev_q     <= have_prev_d;
        end
    end

    assign bus.word_ready    = ready_q;
    assign bus.sample_valid  = sample_valid_q;
    assign bus.sample_data   = sample_data_q;
    assign bus.sample_is_bsl = sample_is_bsl_q;
    assign bus.frame_end     = frame_end_q;
    assign bus.frame_err     = frame_err_q;
    assign bus.hdr_err       = hdr_err_q;
    assign bus.err_count     = err_count_q;
endmodule
